// File: rtl/seg_capture_if.sv
// Pin-side bundle of the seven-segment capture block: strobes/segments in,
// recovered digits, flags and pulses out.
interface seg_capture_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic        frame_done;
  logic        err;

  // master drives the display pins and observes results; slave is the capture block
  modport master (output an, seg, input digits, valid, frame_done, err);
  modport slave  (input an, seg, output digits, valid, frame_done, err);
endinterface

// File: rtl/seg_capture.sv
// Recovers four BCD digits from a multiplexed active-low seven-segment display.
// Optional idle timeout is compiled in with SEG_CAPTURE_TIMEOUT_EN.
module seg_capture #(
  parameter int          SETTLE  = 16,
  parameter logic [31:0] TIMEOUT = 32'h0010_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_capture_if.slave      bus,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 2);

  state_t      state;
  logic [3:0]  an_m, an_s, an_ref;
  logic [6:0]  seg_m, seg_s, seg_ref;
  logic [15:0] cnt;
  logic [3:0]  mask;
  logic        mh_q;
  logic [15:0] digits_q;
  logic [3:0]  valid_q;
  logic        frame_done_q;
  logic        err_q;

  logic [3:0]  an_low;
  logic        one_hot;
  logic        multi_hot;
  logic        idle_pins;
  logic        unchanged;
  logic        take_sample;
  logic [1:0]  sel;
  logic [3:0]  sel_bit;
  logic [3:0]  mask_next;
  logic [3:0]  dec_nib;
  logic        dec_ok;
  logic        dec_blank;

  // Synchronisers reset to the "all dark" pattern so reset never looks like a strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_m  <= 4'hF;
      an_s  <= 4'hF;
      seg_m <= 7'h7F;
      seg_s <= 7'h7F;
    end else begin
      an_m  <= bus.an;
      an_s  <= an_m;
      seg_m <= bus.seg;
      seg_s <= seg_m;
    end
  end

  always_comb begin
    an_low    = ~an_s;
    one_hot   = (an_low != 4'h0) && ((an_low & (an_low - 4'd1)) == 4'h0);
    multi_hot = (an_low & (an_low - 4'd1)) != 4'h0;
    idle_pins = (an_s == 4'hF);
    unchanged = (an_s == an_ref) && (seg_s == seg_ref);
    take_sample = (state == ST_SETTLE) && !multi_hot && !idle_pins &&
                  unchanged && (cnt == SETTLE_LAST);
  end

  // an_ref is always one-hot-low while settling, so this picks the sampled digit
  always_comb begin
    sel = 2'd0;
    case (an_ref)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: sel = 2'd0;
    endcase
    sel_bit   = 4'b0001 << sel;
    mask_next = mask | sel_bit;
  end

  always_comb begin
    dec_nib   = 4'hF;
    dec_ok    = 1'b0;
    dec_blank = 1'b0;
    case (seg_s)
      7'h40: begin dec_nib = 4'd0; dec_ok = 1'b1; end
      7'h79: begin dec_nib = 4'd1; dec_ok = 1'b1; end
      7'h24: begin dec_nib = 4'd2; dec_ok = 1'b1; end
      7'h30: begin dec_nib = 4'd3; dec_ok = 1'b1; end
      7'h19: begin dec_nib = 4'd4; dec_ok = 1'b1; end
      7'h12: begin dec_nib = 4'd5; dec_ok = 1'b1; end
      7'h02: begin dec_nib = 4'd6; dec_ok = 1'b1; end
      7'h78: begin dec_nib = 4'd7; dec_ok = 1'b1; end
      7'h00: begin dec_nib = 4'd8; dec_ok = 1'b1; end
      7'h10: begin dec_nib = 4'd9; dec_ok = 1'b1; end
      7'h7F: dec_blank = 1'b1;
      default: ;
    endcase
  end

`ifdef SEG_CAPTURE_TIMEOUT_EN
  logic [31:0] idle_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      an_ref       <= 4'hF;
      seg_ref      <= 7'h7F;
      cnt          <= 16'h0;
      mask         <= 4'h0;
      mh_q         <= 1'b0;
      digits_q     <= 16'hFFFF;
      valid_q      <= 4'h0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef SEG_CAPTURE_TIMEOUT_EN
      idle_cnt     <= 32'h0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      mh_q         <= multi_hot;
      if (multi_hot) begin
        // only the leading edge of a multi-hot episode is reported
        state <= ST_IDLE;
        cnt   <= 16'h0;
        if (!mh_q) err_q <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (one_hot) begin
              state   <= ST_SETTLE;
              cnt     <= 16'h0;
              an_ref  <= an_s;
              seg_ref <= seg_s;
            end
          end
          ST_SETTLE: begin
            if (idle_pins) begin
              state <= ST_IDLE;
              cnt   <= 16'h0;
            end else if (!unchanged) begin
              cnt     <= 16'h0;
              an_ref  <= an_s;
              seg_ref <= seg_s;
            end else if (take_sample) begin
              state <= ST_HOLD;
              digits_q[{sel, 2'b00} +: 4] <= dec_nib;
              valid_q[sel] <= dec_ok;
              if (!dec_ok && !dec_blank) err_q <= 1'b1;
              if (mask_next == 4'hF) begin
                frame_done_q <= 1'b1;
                mask         <= 4'h0;
              end else begin
                mask <= mask_next;
              end
            end else if (cnt != 16'hFFFF) begin
              cnt <= cnt + 16'd1;
            end
          end
          ST_HOLD: begin
            if (idle_pins) begin
              state <= ST_IDLE;
            end else if (an_s != an_ref) begin
              state   <= ST_SETTLE;
              cnt     <= 16'h0;
              an_ref  <= an_s;
              seg_ref <= seg_s;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
`ifdef SEG_CAPTURE_TIMEOUT_EN
      // Timeout never coincides with a sample, so it cannot fight the writes above
      if (take_sample) begin
        idle_cnt <= 32'h0;
      end else if (idle_cnt != TIMEOUT) begin
        idle_cnt <= idle_cnt + 32'd1;
        if (idle_cnt + 32'd1 == TIMEOUT) begin
          valid_q <= 4'h0;
          mask    <= 4'h0;
          err_q   <= 1'b1;
        end
      end
`endif
    end
  end

  assign bus.digits     = digits_q;
  assign bus.valid      = valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: scans, settle-window boundary, multi-hot,
// bad/blank patterns, mid-frame reset and (if compiled in) idle timeout.
module tb_seg_capture;
  logic       clk;
  logic       rst_n;
  logic [1:0] fsm_state;
  int         checks;
  int         failures;
  int         fd_cnt;
  int         err_cnt;
  int         e0;
  int         f0;

  seg_capture_if bus();

  seg_capture #(.SETTLE(16), .TIMEOUT(32'd100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_done) fd_cnt++;
      if (bus.err) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] s, input int hold, input int blank);
    @(negedge clk);
    bus.an    = 4'hF;
    bus.an[d] = 1'b0;
    bus.seg   = s;
    repeat (hold) @(negedge clk);
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    repeat (blank) @(negedge clk);
  endtask

  task automatic scan_1234();
    show(3, 7'h79, 40, 8);
    show(2, 7'h24, 40, 8);
    show(1, 7'h30, 40, 8);
    show(0, 7'h19, 40, 8);
  endtask

  initial begin
    checks = 0; failures = 0; fd_cnt = 0; err_cnt = 0;
    rst_n = 1'b0; bus.an = 4'hF; bus.seg = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_digits", 32'(bus.digits), 32'hFFFF);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_frame_done", 32'(bus.frame_done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_state", 32'(fsm_state), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_digits", 32'(bus.digits), 32'hFFFF);
    check("idle_valid", 32'(bus.valid), 32'h0);
    check("idle_pulses", 32'(fd_cnt + err_cnt), 32'h0);

    scan_1234();
    check("scan1_digits", 32'(bus.digits), 32'h1234);
    check("scan1_valid", 32'(bus.valid), 32'hF);
    check("scan1_frames", 32'(fd_cnt), 32'd1);
    scan_1234();
    check("scan2_frames", 32'(fd_cnt), 32'd2);
    check("scan2_err", 32'(err_cnt), 32'd0);

    // settle window boundary: 15 stable pin cycles is one short
    do_reset();
    f0 = fd_cnt;
    @(negedge clk);
    bus.an = 4'b1110; bus.seg = 7'h40;
    repeat (15) @(negedge clk);
    bus.an = 4'hF; bus.seg = 7'h7F;
    repeat (20) @(negedge clk);
    check("short_valid", 32'(bus.valid), 32'h0);
    check("short_digits", 32'(bus.digits), 32'hFFFF);
    bus.an = 4'b1110; bus.seg = 7'h40;
    repeat (16) @(negedge clk);
    bus.an = 4'hF; bus.seg = 7'h7F;
    @(negedge clk);
    check("lat_before_valid", 32'(bus.valid), 32'h0);
    @(negedge clk);
    check("lat_valid", 32'(bus.valid), 32'h1);
    check("lat_digit", 32'(bus.digits), 32'hFFF0);
    repeat (10) @(negedge clk);

    e0 = err_cnt;
    bus.an = 4'b1100; bus.seg = 7'h40;
    repeat (10) @(negedge clk);
    check("mh_state", 32'(fsm_state), 32'h0);
    check("mh_err", 32'(err_cnt - e0), 32'd1);
    check("mh_digits", 32'(bus.digits), 32'hFFF0);
    bus.an = 4'hF; bus.seg = 7'h7F;
    repeat (10) @(negedge clk);
    check("mh_err_once", 32'(err_cnt - e0), 32'd1);

    show(2, 7'h12, 30, 8);
    check("d2_five", 32'(bus.digits), 32'hF5F0);
    check("d2_five_valid", 32'(bus.valid), 32'h5);
    e0 = err_cnt;
    show(2, 7'h55, 30, 8);
    check("bad_digits", 32'(bus.digits), 32'hFFF0);
    check("bad_valid", 32'(bus.valid), 32'h1);
    check("bad_err", 32'(err_cnt - e0), 32'd1);
    show(2, 7'h78, 30, 8);
    check("d2_seven", 32'(bus.digits), 32'hF7F0);
    e0 = err_cnt;
    show(2, 7'h7F, 30, 8);
    check("blank_digits", 32'(bus.digits), 32'hFFF0);
    check("blank_valid", 32'(bus.valid), 32'h1);
    check("blank_no_err", 32'(err_cnt - e0), 32'd0);
    check("repeat_no_frame", 32'(fd_cnt - f0), 32'd0);
    show(1, 7'h24, 30, 8);
    show(3, 7'h30, 30, 8);
    check("mixed_frame", 32'(fd_cnt - f0), 32'd1);
    check("mixed_digits", 32'(bus.digits), 32'h3F20);
    check("mixed_valid", 32'(bus.valid), 32'hB);

    // reset mid-frame must drop the partial mask
    show(0, 7'h19, 30, 8);
    show(1, 7'h79, 30, 8);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_digits", 32'(bus.digits), 32'hFFFF);
    check("midrst_valid", 32'(bus.valid), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    f0 = fd_cnt;
    show(2, 7'h02, 30, 8);
    show(3, 7'h00, 30, 8);
    check("midrst_no_frame", 32'(fd_cnt - f0), 32'd0);
    check("midrst_new_digits", 32'(bus.digits), 32'h86FF);

`ifdef SEG_CAPTURE_TIMEOUT_EN
    do_reset();
    scan_1234();
    e0 = err_cnt;
    repeat (150) @(negedge clk);
    check("to_valid", 32'(bus.valid), 32'h0);
    check("to_err", 32'(err_cnt - e0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
